// File: rtl/pwm_audio_out_if.sv
// pwm_audio_out_if: FIFO read port, playback control and PWM/status outputs of pwm_audio_out.
interface pwm_audio_out_if #(
    parameter int DATA_WIDTH = 8,
    parameter int UCNT_WIDTH = 16
);
    logic                  enable;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_r_en;
    logic                  underrun_clr;
    logic                  pwm_out;
    logic                  sample_tick;
    logic [DATA_WIDTH-1:0] duty;
    logic                  underrun;
    logic [UCNT_WIDTH-1:0] underrun_cnt;

    modport master (
        output enable, fifo_empty, fifo_data, underrun_clr,
        input  fifo_r_en, pwm_out, sample_tick, duty, underrun, underrun_cnt
    );

    modport slave (
        input  enable, fifo_empty, fifo_data, underrun_clr,
        output fifo_r_en, pwm_out, sample_tick, duty, underrun, underrun_cnt
    );
endinterface

// File: rtl/pwm_audio_out.sv
// pwm_audio_out: PWM audio DAC fetching one FIFO sample every FRAMES_PER_SAMPLE frames,
// holding the last duty and flagging underruns when the FIFO runs dry.
module pwm_audio_out #(
    parameter int DATA_WIDTH        = 8,
    parameter int FRAMES_PER_SAMPLE = 4,
    parameter int UCNT_WIDTH        = 16
) (
    input logic clk,
    input logic rst,
    pwm_audio_out_if.slave bus
);
    localparam int FW = FRAMES_PER_SAMPLE > 1 ? $clog2(FRAMES_PER_SAMPLE) : 1;
    localparam logic [DATA_WIDTH-1:0] MAX      = '1;
    localparam logic [DATA_WIDTH-1:0] FETCH_AT = MAX - DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] MID      = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
    localparam logic [FW-1:0]         FLAST    = FW'(FRAMES_PER_SAMPLE - 1);

    logic [DATA_WIDTH-1:0] cnt_q, cnt_d, duty_q, duty_d;
    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic [UCNT_WIDTH-1:0] ucnt_q, ucnt_d, ucnt_base;
    logic                  pwm_q, pwm_d, got_q, got_d, underrun_q, underrun_d;
    logic                  fetch, ev;

    assign fetch = bus.enable && fcnt_q == FLAST && cnt_q == FETCH_AT;
    assign ev    = fetch && bus.fifo_empty;

    always_comb begin
        cnt_d      = bus.enable ? cnt_q + 1'b1 : '0;
        fcnt_d     = !bus.enable ? '0 : cnt_q != MAX ? fcnt_q : fcnt_q == FLAST ? '0 : fcnt_q + 1'b1;
        pwm_d      = bus.enable && (cnt_q < duty_q);
        got_d      = fetch && !bus.fifo_empty;
        // a disable landing on the load cycle drops that sample
        duty_d     = (bus.enable && got_q) ? bus.fifo_data : duty_q;
        underrun_d = ev || (underrun_q && !bus.underrun_clr);
        ucnt_base  = bus.underrun_clr ? '0 : ucnt_q;
        ucnt_d     = (ev && ucnt_base != '1) ? ucnt_base + 1'b1 : ucnt_base;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            fcnt_q     <= '0;
            duty_q     <= MID;
            pwm_q      <= 1'b0;
            got_q      <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            fcnt_q     <= fcnt_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            got_q      <= got_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    assign bus.fifo_r_en    = fetch && !bus.fifo_empty;
    assign bus.sample_tick  = bus.enable && cnt_q == '0 && fcnt_q == '0;
    assign bus.pwm_out      = pwm_q;
    assign bus.duty         = duty_q;
    assign bus.underrun     = underrun_q;
    assign bus.underrun_cnt = ucnt_q;
endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out: directed tests of pwm_audio_out (DATA_WIDTH=8, FRAMES_PER_SAMPLE=2) against a queue-backed FIFO.
module tb_pwm_audio_out;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0, failures = 0, cyc = 0, reads = 0, rd_err = 0, rbase = 0;
    logic [7:0] fq[$];

    pwm_audio_out_if #(.DATA_WIDTH(8), .UCNT_WIDTH(16)) bus();

    pwm_audio_out #(.DATA_WIDTH(8), .FRAMES_PER_SAMPLE(2), .UCNT_WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = 8'h00;
    end

    always @(posedge clk) begin
        if (bus.fifo_r_en) begin
            reads++;
            if (fq.size() == 0) rd_err++;
            else bus.fifo_data <= fq.pop_front();
        end
    end

    always @(negedge clk) bus.fifo_empty <= (fq.size() == 0);

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            step();
            hi += int'(bus.pwm_out);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.enable = 1'b0;
        bus.underrun_clr = 1'b0;
        fq.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic go();
        rst = 1'b1;
        @(negedge clk);
        bus.enable = 1'b1;
        cyc = 0;
        rbase = reads;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.duty !== 8'h80) begin failures++; $display("FAIL reset_duty got=%0h exp=80", bus.duty); end
        checks++; if (bus.pwm_out !== 1'b0) begin failures++; $display("FAIL reset_pwm got=%0b exp=0", bus.pwm_out); end
        checks++; if (bus.fifo_r_en !== 1'b0) begin failures++; $display("FAIL reset_ren got=%0b exp=0", bus.fifo_r_en); end
        checks++; if (bus.sample_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%0b exp=0", bus.sample_tick); end
        checks++; if (bus.underrun !== 1'b0 || bus.underrun_cnt !== 16'd0) begin failures++; $display("FAIL reset_underrun got=%0b/%0d exp=0/0", bus.underrun, bus.underrun_cnt); end
    endtask

    task automatic test_empty_fifo();
        int hi;
        do_reset();
        go();
        goto(1);
        count_high(256, hi);
        checks++; if (hi !== 128) begin failures++; $display("FAIL empty_pwm_high got=%0d exp=128", hi); end
        goto(509);
        checks++; if (bus.fifo_r_en !== 1'b0 || bus.underrun !== 1'b0) begin failures++; $display("FAIL empty_fetch got=ren%0b/ur%0b exp=0/0", bus.fifo_r_en, bus.underrun); end
        goto(510);
        checks++; if (bus.underrun !== 1'b1 || bus.underrun_cnt !== 16'd1) begin failures++; $display("FAIL empty_ucnt1 got=%0b/%0d exp=1/1", bus.underrun, bus.underrun_cnt); end
        goto(511);
        checks++; if (bus.sample_tick !== 1'b0) begin failures++; $display("FAIL tick_511 got=%0b exp=0", bus.sample_tick); end
        goto(512);
        checks++; if (bus.sample_tick !== 1'b1) begin failures++; $display("FAIL tick_512 got=%0b exp=1", bus.sample_tick); end
        goto(1021);
        checks++; if (bus.underrun_cnt !== 16'd1) begin failures++; $display("FAIL empty_ucnt_1021 got=%0d exp=1", bus.underrun_cnt); end
        goto(1022);
        checks++; if (bus.underrun_cnt !== 16'd2 || bus.duty !== 8'h80) begin failures++; $display("FAIL empty_ucnt2 got=%0d/duty%0h exp=2/80", bus.underrun_cnt, bus.duty); end
        checks++; if (reads - rbase !== 0) begin failures++; $display("FAIL empty_reads got=%0d exp=0", reads - rbase); end
    endtask

    task automatic test_load();
        int hi;
        do_reset();
        fq.push_back(8'h40);
        fq.push_back(8'hC0);
        go();
        goto(508);
        checks++; if (bus.fifo_r_en !== 1'b0) begin failures++; $display("FAIL load_ren_508 got=%0b exp=0", bus.fifo_r_en); end
        goto(509);
        checks++; if (bus.fifo_r_en !== 1'b1) begin failures++; $display("FAIL load_ren_509 got=%0b exp=1", bus.fifo_r_en); end
        goto(510);
        checks++; if (bus.fifo_r_en !== 1'b0 || bus.duty !== 8'h80) begin failures++; $display("FAIL load_510 got=ren%0b/duty%0h exp=0/80", bus.fifo_r_en, bus.duty); end
        goto(511);
        checks++; if (bus.duty !== 8'h40) begin failures++; $display("FAIL load_duty40 got=%0h exp=40", bus.duty); end
        goto(512);
        count_high(256, hi);
        checks++; if (hi !== 64) begin failures++; $display("FAIL load_pwm64 got=%0d exp=64", hi); end
        goto(1021);
        checks++; if (bus.fifo_r_en !== 1'b1) begin failures++; $display("FAIL load_ren_1021 got=%0b exp=1", bus.fifo_r_en); end
        goto(1023);
        checks++; if (bus.duty !== 8'hC0) begin failures++; $display("FAIL load_dutyC0 got=%0h exp=c0", bus.duty); end
        goto(1024);
        count_high(256, hi);
        checks++; if (hi !== 192) begin failures++; $display("FAIL load_pwm192 got=%0d exp=192", hi); end
        goto(1533);
        checks++; if (bus.fifo_r_en !== 1'b0) begin failures++; $display("FAIL load_ren_empty got=%0b exp=0", bus.fifo_r_en); end
        goto(1535);
        checks++; if (bus.underrun !== 1'b1 || bus.duty !== 8'hC0) begin failures++; $display("FAIL load_hold got=ur%0b/duty%0h exp=1/c0", bus.underrun, bus.duty); end
        checks++; if (reads - rbase !== 2 || rd_err !== 0) begin failures++; $display("FAIL load_reads got=%0d/err%0d exp=2/0", reads - rbase, rd_err); end
    endtask

    task automatic test_extremes();
        int hi;
        do_reset();
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        go();
        goto(512);
        count_high(256, hi);
        checks++; if (hi !== 0) begin failures++; $display("FAIL duty00_pwm got=%0d exp=0", hi); end
        goto(1024);
        count_high(256, hi);
        checks++; if (hi !== 255) begin failures++; $display("FAIL dutyFF_pwm got=%0d exp=255", hi); end
    endtask

    task automatic test_underrun_clr();
        do_reset();
        fq.push_back(8'h40);
        go();
        goto(1022);
        checks++; if (bus.duty !== 8'h40 || bus.underrun !== 1'b1 || bus.underrun_cnt !== 16'd1) begin failures++; $display("FAIL ur_first got=duty%0h/%0b/%0d exp=40/1/1", bus.duty, bus.underrun, bus.underrun_cnt); end
        goto(1534);
        checks++; if (bus.underrun_cnt !== 16'd2) begin failures++; $display("FAIL ur_cnt2 got=%0d exp=2", bus.underrun_cnt); end
        goto(1600);
        bus.underrun_clr = 1'b1;
        step();
        bus.underrun_clr = 1'b0;
        checks++; if (bus.underrun !== 1'b0 || bus.underrun_cnt !== 16'd0) begin failures++; $display("FAIL ur_clear got=%0b/%0d exp=0/0", bus.underrun, bus.underrun_cnt); end
        goto(2046);
        checks++; if (bus.underrun_cnt !== 16'd1) begin failures++; $display("FAIL ur_after_clr got=%0d exp=1", bus.underrun_cnt); end
        goto(2557);
        bus.underrun_clr = 1'b1;
        step();
        bus.underrun_clr = 1'b0;
        checks++; if (bus.underrun !== 1'b1 || bus.underrun_cnt !== 16'd1) begin failures++; $display("FAIL ur_clr_coincident got=%0b/%0d exp=1/1", bus.underrun, bus.underrun_cnt); end
        checks++; if (reads - rbase !== 1 || rd_err !== 0) begin failures++; $display("FAIL ur_reads got=%0d/err%0d exp=1/0", reads - rbase, rd_err); end
    endtask

    task automatic test_enable_toggle();
        int hi, rd;
        do_reset();
        fq.push_back(8'h40);
        fq.push_back(8'hC0);
        go();
        goto(511);
        checks++; if (bus.duty !== 8'h40) begin failures++; $display("FAIL en_pre_duty got=%0h exp=40", bus.duty); end
        goto(600);
        bus.enable = 1'b0;
        hi = 0;
        rd = 0;
        repeat (100) begin
            step();
            hi += int'(bus.pwm_out);
            rd += int'(bus.fifo_r_en);
        end
        checks++; if (hi !== 0 || rd !== 0) begin failures++; $display("FAIL en_low got=pwm%0d/ren%0d exp=0/0", hi, rd); end
        checks++; if (bus.sample_tick !== 1'b0) begin failures++; $display("FAIL en_low_tick got=%0b exp=0", bus.sample_tick); end
        bus.enable = 1'b1;
        cyc = 0;
        #1;
        checks++; if (bus.sample_tick !== 1'b1 || bus.duty !== 8'h40) begin failures++; $display("FAIL en_resume got=tick%0b/duty%0h exp=1/40", bus.sample_tick, bus.duty); end
        goto(509);
        checks++; if (bus.fifo_r_en !== 1'b1) begin failures++; $display("FAIL en_resume_ren got=%0b exp=1", bus.fifo_r_en); end
        goto(511);
        checks++; if (bus.duty !== 8'hC0 || reads - rbase !== 2) begin failures++; $display("FAIL en_resume_load got=duty%0h/rd%0d exp=c0/2", bus.duty, reads - rbase); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fq.push_back(8'h40);
        fq.push_back(8'hC0);
        fq.push_back(8'h20);
        go();
        goto(1030);
        checks++; if (bus.pwm_out !== 1'b1 || bus.duty !== 8'hC0) begin failures++; $display("FAIL rmid_pre got=pwm%0b/duty%0h exp=1/c0", bus.pwm_out, bus.duty); end
        rst = 1'b0;
        #1;
        checks++; if (bus.pwm_out !== 1'b0 || bus.duty !== 8'h80) begin failures++; $display("FAIL rmid_async got=pwm%0b/duty%0h exp=0/80", bus.pwm_out, bus.duty); end
        do_reset();
        fq.push_back(8'h40);
        go();
        goto(509);
        checks++; if (bus.fifo_r_en !== 1'b1) begin failures++; $display("FAIL rpend_ren got=%0b exp=1", bus.fifo_r_en); end
        goto(510);
        rst = 1'b0;
        #1;
        checks++; if (bus.fifo_r_en !== 1'b0 || bus.duty !== 8'h80 || bus.underrun !== 1'b0) begin failures++; $display("FAIL rpend_async got=ren%0b/duty%0h/ur%0b exp=0/80/0", bus.fifo_r_en, bus.duty, bus.underrun); end
        repeat (3) @(negedge clk);
        checks++; if (bus.duty !== 8'h80 || reads - rbase !== 1) begin failures++; $display("FAIL rpend_hold got=duty%0h/rd%0d exp=80/1", bus.duty, reads - rbase); end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.underrun_clr = 1'b0;
        test_reset();
        test_empty_fifo();
        test_load();
        test_extremes();
        test_underrun_clr();
        test_enable_toggle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
